// File: rtl/sat_accum_pkg.sv
// rtl/sat_accum_pkg.sv - shared constants and helpers for the saturating accumulator
package sat_accum_pkg;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    // Channel index width; a single channel still gets a one-bit index port.
    function automatic int ch_w(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

    // Largest signed value of an m-bit word (0 1..1), zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int m);
        return (64'd1 << (m - 1)) - 64'd1;
    endfunction

    // Smallest signed value of an m-bit word (1 0..0) in the low m bits.
    function automatic logic [63:0] sat_min(input int m);
        return ~sat_max(m);
    endfunction

endpackage

// File: rtl/sat_addsub_core.sv
// rtl/sat_addsub_core.sv - combinational saturating add/sub with optional SAT_ACCUM_LIMIT_EN clamp
module sat_addsub_core
    import sat_accum_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int M_ACC = 24
) (
    input  logic [M_ACC-1:0] acc,
    input  logic             clr,
    input  logic             op,
    input  logic [N_IN-1:0]  x,
`ifdef SAT_ACCUM_LIMIT_EN
    input  logic [M_ACC-1:0] lim_hi,
    input  logic [M_ACC-1:0] lim_lo,
`endif
    output logic [M_ACC-1:0] res,
    output logic             ov
);

    localparam logic [M_ACC-1:0] ACC_MAX = M_ACC'(sat_max(M_ACC));
    localparam logic [M_ACC-1:0] ACC_MIN = M_ACC'(sat_min(M_ACC));

    logic [M_ACC:0]   a_ext;
    logic [M_ACC:0]   x_ext;
    logic [M_ACC:0]   sum;
    logic [M_ACC-1:0] sat_val;
    logic             full_ov;

    // Extend both operands by one guard bit, add/sub, then clamp to the full M_ACC range.
    always_comb begin
        a_ext   = clr ? '0 : {acc[M_ACC-1], acc};
        x_ext   = {{(M_ACC + 1 - N_IN){x[N_IN-1]}}, x};
        sum     = (op == OP_ADD) ? (a_ext + x_ext) : (a_ext - x_ext);
        full_ov = (sum[M_ACC] != sum[M_ACC-1]);
        if (full_ov) begin
            sat_val = sum[M_ACC] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_val = sum[M_ACC-1:0];
        end
    end

`ifdef SAT_ACCUM_LIMIT_EN
    // Anti-windup: pull the full-range result into [lim_lo, lim_hi] and flag it as saturated.
    always_comb begin
        res = sat_val;
        ov  = full_ov;
        if ($signed(sat_val) > $signed(lim_hi)) begin
            res = lim_hi;
            ov  = 1'b1;
        end else if ($signed(sat_val) < $signed(lim_lo)) begin
            res = lim_lo;
            ov  = 1'b1;
        end
    end
`else
    assign res = sat_val;
    assign ov  = full_ov;
`endif

endmodule

// File: rtl/sat_accum_mc.sv
// rtl/sat_accum_mc.sv - multi-channel saturating accumulator top, optional SAT_ACCUM_LIMIT_EN limits
module sat_accum_mc
    import sat_accum_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int M_ACC = 24,
    parameter int CH    = 4,
    parameter int CH_W  = ch_w(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [N_IN-1:0]  in_data,
    input  logic             in_op,
    input  logic             in_clr,
`ifdef SAT_ACCUM_LIMIT_EN
    input  logic [M_ACC-1:0] lim_hi,
    input  logic [M_ACC-1:0] lim_lo,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [M_ACC-1:0] out_data,
    output logic             out_ov,
    output logic [CH-1:0]    ov_sticky,
    input  logic [CH-1:0]    ov_clr
);

    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH);

    logic             xfer;
    logic             ch_ok;
    logic             hit;
    logic [M_ACC-1:0] acc [CH];
    logic [M_ACC-1:0] acc_rd;
    logic [M_ACC-1:0] res;
    logic             res_ov;

    // Single output register, no skid: accept whenever that register is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign ch_ok    = ({1'b0, in_ch} < CH_LIM);
    assign hit      = xfer && ch_ok;

    // Select the addressed accumulator; out-of-range channels read as zero and are dropped later.
    always_comb begin
        acc_rd = '0;
        for (int c = 0; c < CH; c++) begin
            if (in_ch == CH_W'(c)) begin
                acc_rd = acc[c];
            end
        end
    end

    sat_addsub_core #(
        .N_IN  (N_IN),
        .M_ACC (M_ACC)
    ) u_core (
        .acc    (acc_rd),
        .clr    (in_clr),
        .op     (in_op),
        .x      (in_data),
`ifdef SAT_ACCUM_LIMIT_EN
        .lim_hi (lim_hi),
        .lim_lo (lim_lo),
`endif
        .res    (res),
        .ov     (res_ov)
    );

    // Accumulators are written at the accepting edge, so back-to-back samples see fresh values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                acc[c] <= '0;
            end
        end else if (hit) begin
            for (int c = 0; c < CH; c++) begin
                if (in_ch == CH_W'(c)) begin
                    acc[c] <= res;
                end
            end
        end
    end

    // Output stage: load on a valid-channel transfer, hold while stalled, empty when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ov    <= 1'b0;
        end else if (hit) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= res;
            out_ov    <= res_ov;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky saturation flags; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_sticky <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (hit && res_ov && (in_ch == CH_W'(c))) begin
                    ov_sticky[c] <= 1'b1;
                end else if (ov_clr[c]) begin
                    ov_sticky[c] <= 1'b0;
                end
            end
        end
    end

endmodule
